// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM state encoding and port ids.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Combinational 2-way round-robin picker; on a tie the port not served last wins.
module rr_pick2
  import mem_port_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic gnt_valid,
  output logic gnt_id
);

  always_comb begin
    // NOTE: every output gets a default before the branches so no latch is inferred.
    gnt_valid = req0 | req1;
    gnt_id    = PORT_CPU;
    if (req0 && req1) gnt_id = ~last;
    else if (req1)    gnt_id = PORT_DMA;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter/sequencer for the shared memory port: grants one requester,
// holds its latched transaction on the memory side until m_ready, then pulses ack.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_adr,
  input  logic [DW-1:0] p0_wd,
  output logic          p0_ack,
  output logic [DW-1:0] p0_rd,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_adr,
  input  logic [DW-1:0] p1_wd,
  output logic          p1_ack,
  output logic [DW-1:0] p1_rd,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_adr,
  output logic [DW-1:0] m_wd,
  input  logic [DW-1:0] m_rd,
  input  logic          m_ready,
  output logic          busy
);

  arb_state_e state;
  logic       sel;
  logic       last_gnt;
  logic       gnt_valid;
  logic       gnt_id;

  rr_pick2 u_pick (
    .req0      (p0_req),
    .req1      (p1_req),
    .last      (last_gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  // m_adr/m_wd/m_we are the latched transaction itself, so the memory side never
  // sees the ports combinationally and a misbehaving requester cannot disturb it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ARB_IDLE;
      sel      <= PORT_CPU;
      last_gnt <= PORT_DMA;
      m_req    <= 1'b0;
      m_we     <= 1'b0;
      m_adr    <= '0;
      m_wd     <= '0;
      p0_ack   <= 1'b0;
      p1_ack   <= 1'b0;
      p0_rd    <= '0;
      p1_rd    <= '0;
      busy     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      p0_ack <= 1'b0;
      p1_ack <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (gnt_valid) begin
            sel      <= gnt_id;
            last_gnt <= gnt_id;
            m_req    <= 1'b1;
            busy     <= 1'b1;
            state    <= ARB_ACCESS;
            if (gnt_id == PORT_DMA) begin
              m_we  <= p1_we;
              m_adr <= p1_adr;
              m_wd  <= p1_wd;
            end else begin
              m_we  <= p0_we;
              m_adr <= p0_adr;
              m_wd  <= p0_wd;
            end
          end
        end
        ARB_ACCESS: begin
          if (m_ready) begin
            m_req <= 1'b0;
            m_we  <= 1'b0;
            state <= ARB_RESP;
            if (sel == PORT_DMA) begin
              p1_ack <= 1'b1;
              if (!m_we) p1_rd <= m_rd;
            end else begin
              p0_ack <= 1'b1;
              if (!m_we) p0_rd <= m_rd;
            end
          end
        end
        ARB_RESP: begin
          busy  <= 1'b0;
          state <= ARB_IDLE;
        end
        default: begin
          m_req <= 1'b0;
          m_we  <= 1'b0;
          busy  <= 1'b0;
          state <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requesters push expected read data, a monitor
// pops on each ack; a behavioural memory supplies wait states and stray m_ready pulses.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
  logic [31:0] p0_adr = '0, p0_wd = '0, p1_adr = '0, p1_wd = '0;
  logic        p0_ack, p1_ack, m_req, m_we, busy;
  logic [31:0] p0_rd, p1_rd, m_adr, m_wd;
  logic [31:0] m_rd = '0;
  logic        m_ready = 1'b0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // memory environment knobs
  int fixed_w = 0;
  bit rand_w  = 1'b0;
  bit stray   = 1'b0;

  logic [31:0] ram    [logic [31:0]];
  logic [31:0] shadow [logic [31:0]];
  logic [31:0] last_rd [2];
  logic [31:0] exp_q0 [$];
  logic [31:0] exp_q1 [$];

  mem_port_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_adr(p0_adr), .p0_wd(p0_wd),
    .p0_ack(p0_ack), .p0_rd(p0_rd),
    .p1_req(p1_req), .p1_we(p1_we), .p1_adr(p1_adr), .p1_wd(p1_wd),
    .p1_ack(p1_ack), .p1_rd(p1_rd),
    .m_req(m_req), .m_we(m_we), .m_adr(m_adr), .m_wd(m_wd),
    .m_rd(m_rd), .m_ready(m_ready), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] initval(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Issue one transaction on a port and block until its ack (bounded).
  task automatic issue(input int port, input logic we, input logic [31:0] adr,
                       input logic [31:0] wd, output int ack_cyc);
    logic [31:0] e;
    if (we) begin
      shadow[adr] = wd;
      e = last_rd[port];
    end else begin
      e = shadow.exists(adr) ? shadow[adr] : initval(adr);
      last_rd[port] = e;
    end
    if (port == 0) begin
      exp_q0.push_back(e);
      p0_we = we; p0_adr = adr; p0_wd = wd; p0_req = 1'b1;
    end else begin
      exp_q1.push_back(e);
      p1_we = we; p1_adr = adr; p1_wd = wd; p1_req = 1'b1;
    end
    ack_cyc = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if ((port == 0) ? p0_ack : p1_ack) begin
        ack_cyc = cyc;
        break;
      end
    end
    if (ack_cyc < 0) check($sformatf("ack timeout p%0d", port), 32'd0, 32'd1);
    if (port == 0) p0_req = 1'b0; else p1_req = 1'b0;
  endtask

  task automatic port_loop(input int port, input int n);
    int          ac, st;
    logic [31:0] base;
    base = (port == 0) ? 32'h0000_0000 : 32'h0000_0400;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      st = cyc;
      issue(port, 1'($urandom % 2), base + 32'(($urandom % 16) * 4), $urandom, ac);
      check($sformatf("p%0d min latency", port), 32'(ac - st >= 2), 32'd1);
    end
  endtask

  // Behavioural memory: counts wait states per access, commits writes on completion.
  initial begin : memory
    int          wcnt, cur_w;
    bit          in_acc;
    logic [31:0] acc_adr;
    in_acc = 1'b0; wcnt = 0; cur_w = 0; acc_adr = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        m_ready = 1'b0;
        in_acc  = 1'b0;
      end else if (m_req) begin
        if (!in_acc) begin
          in_acc  = 1'b1;
          wcnt    = 0;
          cur_w   = rand_w ? int'($urandom_range(0, 3)) : fixed_w;
          acc_adr = m_adr;
        end else begin
          check("m_adr stable in access", m_adr, acc_adr);
        end
        if (wcnt == cur_w) begin
          m_ready = 1'b1;
          if (m_we) ram[m_adr] = m_wd;
          else      m_rd = ram.exists(m_adr) ? ram[m_adr] : initval(m_adr);
        end else begin
          m_ready = 1'b0;
          m_rd    = $urandom;
          wcnt++;
        end
      end else begin
        in_acc  = 1'b0;
        m_ready = stray ? 1'($urandom % 2) : 1'b0;
        m_rd    = $urandom;
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (p0_ack || p1_ack) check("acks exclusive", 32'(p0_ack & p1_ack), 32'd0);
      if (m_req) check("busy with m_req", 32'(busy), 32'd1);
      if (p0_ack) begin
        if (exp_q0.size() == 0) check("p0 unexpected ack", 32'd1, 32'd0);
        else check("p0_rd at ack", p0_rd, exp_q0.pop_front());
      end
      if (p1_ack) begin
        if (exp_q1.size() == 0) check("p1 unexpected ack", 32'd1, 32'd0);
        else check("p1_rd at ack", p1_rd, exp_q1.pop_front());
      end
    end
  end

  initial begin : stim
    int a0, a1, b0, b1, c0, n;
    last_rd[0] = '0;
    last_rd[1] = '0;
    repeat (3) @(negedge clk);
    check("reset m_req", 32'(m_req), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset acks", {30'd0, p1_ack, p0_ack}, 32'd0);
    check("reset m_adr", m_adr, 32'd0);
    check("reset rd", p0_rd | p1_rd | m_wd, 32'd0);
    reset_n = 1'b1;

    // reset in the middle of a stalled read: abandoned, no ack
    fixed_w = 1000;
    @(negedge clk);
    p0_we = 1'b0; p0_adr = 32'h40; p0_req = 1'b1;
    @(negedge clk);
    check("m_req stalled access", 32'(m_req), 32'd1);
    check("m_adr stalled access", m_adr, 32'h40);
    #2 reset_n = 1'b0;
    #1;
    check("async reset m_req", 32'(m_req), 32'd0);
    check("async reset busy", 32'(busy), 32'd0);
    p0_req = 1'b0;
    repeat (2) @(negedge clk);
    check("no ack after abort", {30'd0, p1_ack, p0_ack}, 32'd0);
    fixed_w = 0;
    last_rd[0] = '0;
    last_rd[1] = '0;
    reset_n = 1'b1;

    // continuous contention straight from reset: order 0,1,0,1 every 3 cycles
    c0 = cyc;
    fork
      begin issue(0, 1'b0, 32'h80, '0, a0); issue(0, 1'b0, 32'h84, '0, a1); end
      begin issue(1, 1'b0, 32'h480, '0, b0); issue(1, 1'b0, 32'h484, '0, b1); end
    join
    check("contention ack p0 #1", 32'(a0 - c0), 32'd2);
    check("contention ack p1 #1", 32'(b0 - c0), 32'd5);
    check("contention ack p0 #2", 32'(a1 - c0), 32'd8);
    check("contention ack p1 #2", 32'(b1 - c0), 32'd11);

    // zero-wait read of 0x100
    @(negedge clk);
    ram[32'h100] = 32'hDEADBEEF;
    shadow[32'h100] = 32'hDEADBEEF;
    c0 = cyc;
    fork
      issue(0, 1'b0, 32'h100, '0, a0);
      begin
        @(negedge clk);
        check("read m_req cycle1", 32'(m_req), 32'd1);
        check("read m_adr cycle1", m_adr, 32'h100);
      end
    join
    check("read latency", 32'(a0 - c0), 32'd2);
    check("read p0_rd", p0_rd, 32'hDEADBEEF);

    // port-1 write with 3 wait states
    @(negedge clk);
    fixed_w = 3;
    c0 = cyc;
    fork
      issue(1, 1'b1, 32'h200, 32'h55AA00FF, a1);
      begin
        n = 0;
        repeat (6) begin
          @(negedge clk);
          if (m_we) n++;
        end
        check("write m_we cycles", 32'(n), 32'd4);
      end
    join
    check("write latency", 32'(a1 - c0), 32'd5);
    check("write mem data", ram[32'h200], 32'h55AA00FF);

    // address changed by port 0 mid-access: memory keeps the latched address
    @(negedge clk);
    fixed_w = 2;
    fork
      issue(0, 1'b0, 32'h10, '0, a0);
      begin
        @(negedge clk);
        p0_adr = 32'h20;
        for (int i = 0; i < 3; i++) begin
          check("latched m_adr", m_adr, 32'h10);
          @(negedge clk);
        end
      end
    join

    // stray m_ready outside ACCESS
    fixed_w = 1;
    stray   = 1'b1;
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy) n++;
    end
    check("stray m_ready idle busy", 32'(n), 32'd0);
    issue(0, 1'b0, 32'h30, '0, a0);
    repeat (5) @(negedge clk);
    check("p0_rd after stray", p0_rd, last_rd[0]);
    check("p1_rd after stray", p1_rd, last_rd[1]);

    // randomized traffic from both ports with random wait states
    rand_w = 1'b1;
    fork
      port_loop(0, 30);
      port_loop(1, 30);
    join
    repeat (6) @(negedge clk);
    check("q0 drained", 32'(exp_q0.size()), 32'd0);
    check("q1 drained", 32'(exp_q1.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
